ex_div_unit: RTL and testbench



---
 rtl/ex_div_unit.sv | 150 +++++++++++++++
 tb/tb_ex_div_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Optional build macro: EX_DIV_EARLY_OUT_EN (finish at once when |dividend| < |divisor|).
module ex_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            BUSYWAIT,
  output logic [XLEN-1:0] RESULT,
  output logic            DONE
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_divisor;
  logic [XLEN:0]     r_rem;
  logic [CntW-1:0]   r_count;
  logic              r_rem_sel;
  logic              r_qneg;
  logic              r_rneg;
  logic [XLEN-1:0]   r_result;

  // Codes without FUNC3[2] set decode as DIVU.
  logic              w_signed, w_rem_sel;
  logic [XLEN-1:0]   w_abs1, w_abs2;
  logic              w_div_zero, w_ovf, w_early, w_short;
  logic [XLEN-1:0]   w_short_res;
  logic [XLEN:0]     w_rem_shift, w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix;
  logic              w_last;
  logic              w_unused_rem_msb;

  assign w_signed   = FUNC3[2] & ~FUNC3[0];
  assign w_rem_sel  = FUNC3[2] & FUNC3[1];
  assign w_abs1     = (w_signed && DATA1[XLEN-1]) ? -DATA1 : DATA1;
  assign w_abs2     = (w_signed && DATA2[XLEN-1]) ? -DATA2 : DATA2;
  assign w_div_zero = (DATA2 == '0);
  assign w_ovf      = w_signed && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (&DATA2);

`ifdef EX_DIV_EARLY_OUT_EN
  assign w_early    = (w_abs1 < w_abs2);
`else
  assign w_early    = 1'b0;
`endif

  assign w_short    = w_div_zero | w_ovf | w_early;

  always_comb begin
    w_short_res = '0;
    if (w_div_zero) begin
      w_short_res = w_rem_sel ? DATA1 : '1;
    end else if (w_ovf) begin
      w_short_res = w_rem_sel ? '0 : DATA1;
    end else begin
      w_short_res = w_rem_sel ? DATA1 : '0;
    end
  end

  // Partial remainder stays below the divisor, so the top bit of the XLEN+1 diff is the borrow.
  assign w_rem_shift      = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_diff           = w_rem_shift - {1'b0, r_divisor};
  assign w_ge             = ~w_diff[XLEN];
  assign w_unused_rem_msb = r_rem[XLEN];
  assign w_last           = (r_count == CntW'(XLEN - 1));

  assign w_quo_fix = r_qneg ? -r_quo : r_quo;
  assign w_rem_fix = r_rneg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  always_comb begin
    w_state_next = r_state;
    BUSYWAIT     = 1'b0;
    DONE         = 1'b0;
    unique case (r_state)
      StIdle: begin
        BUSYWAIT = START;
        if (START) begin
          w_state_next = w_short ? StDone : StCalc;
        end
      end
      StCalc: begin
        BUSYWAIT = 1'b1;
        if (w_last) begin
          w_state_next = StFixup;
        end
      end
      StFixup: begin
        BUSYWAIT     = 1'b1;
        w_state_next = StDone;
      end
      StDone: begin
        DONE         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= StIdle;
      r_quo     <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_rem_sel <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (START) begin
            r_quo     <= w_abs1;
            r_divisor <= w_abs2;
            r_rem     <= '0;
            r_count   <= '0;
            r_rem_sel <= w_rem_sel;
            r_qneg    <= w_signed & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
            r_rneg    <= w_signed & DATA1[XLEN-1];
            if (w_short) begin
              r_result <= w_short_res;
            end
          end
        end
        StCalc: begin
          r_rem   <= w_ge ? w_diff : w_rem_shift;
          r_quo   <= {r_quo[XLEN-2:0], w_ge};
          r_count <= r_count + CntW'(1);
        end
        StFixup: begin
          r_result <= r_rem_sel ? w_rem_fix : w_quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign RESULT = r_result;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed, table-driven self-checking bench for ex_div_unit.
module tb_ex_div_unit;

  localparam int NormBusy = 34;
`ifdef EX_DIV_EARLY_OUT_EN
  localparam int EoBusy = 1;
`else
  localparam int EoBusy = 34;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNC3;
  logic [31:0] DATA1, DATA2;
  logic        BUSYWAIT;
  logic [31:0] RESULT;
  logic        DONE;

  int checks   = 0;
  int failures = 0;

  ex_div_unit #(.XLEN(32)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .FUNC3    (FUNC3),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .BUSYWAIT (BUSYWAIT),
    .RESULT   (RESULT),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          busy;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  // START is left high so a caller can chain a second instruction.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_busy, input string name);
    int busy = 0;
    bit got_done = 0;
    START = 1'b1;
    FUNC3 = f;
    DATA1 = a;
    DATA2 = b;
    for (int c = 0; c < 200 && !got_done; c++) begin
      @(negedge CLK);
      if (DONE) begin
        got_done = 1;
        check({name, " result"}, RESULT, exp_res);
        check({name, " busy_at_done"}, {31'b0, BUSYWAIT}, 32'd0);
      end else if (BUSYWAIT) begin
        busy++;
      end
      @(posedge CLK);
      #1;
      if (!got_done) begin
        DATA1 = ~a ^ 32'h5a5a_1234;
        DATA2 = b + 32'd3;
      end
    end
    if (!got_done) begin
      failures++;
      $display("FAIL %s timeout: got no DONE expected DONE within 200 cycles", name);
    end
    check({name, " busy_cycles"}, busy, exp_busy);
  endtask

  task automatic idle_cycle(input string name);
    START = 1'b0;
    @(negedge CLK);
    check({name, " idle_done"}, {31'b0, DONE}, 32'd0);
    check({name, " idle_busy"}, {31'b0, BUSYWAIT}, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int done_seen;
    vecs[0]  = '{3'b101, 32'd100,        32'd7,          32'd14,         NormBusy, "divu_100_7"};
    vecs[1]  = '{3'b111, 32'd100,        32'd7,          32'd2,          NormBusy, "remu_100_7"};
    vecs[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NormBusy, "div_m7_2"};
    vecs[3]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NormBusy, "rem_m7_2"};
    vecs[4]  = '{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          NormBusy, "rem_7_m2"};
    vecs[5]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,        "div_5_0"};
    vecs[6]  = '{3'b111, 32'd5,          32'd0,          32'd5,          1,        "remu_5_0"};
    vecs[7]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,        "div_ovf"};
    vecs[8]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,        "rem_ovf"};
    vecs[9]  = '{3'b101, 32'd3,          32'd10,         32'd0,          EoBusy,   "divu_3_10"};
    vecs[10] = '{3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         NormBusy, "div_m100_m7"};
    vecs[11] = '{3'b110, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  NormBusy, "rem_m100_m7"};
    vecs[12] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NormBusy, "divu_max_1"};
    vecs[13] = '{3'b000, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  NormBusy, "f000_as_divu"};
    vecs[14] = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  EoBusy,   "remu_min_max"};
    vecs[15] = '{3'b100, 32'h8000_0000,  32'd2,          32'hC000_0000,  NormBusy, "div_min_2"};

    RESET = 1'b1;
    START = 1'b0;
    FUNC3 = 3'b000;
    DATA1 = '0;
    DATA2 = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_busy", {31'b0, BUSYWAIT}, 32'd0);
    check("reset_done", {31'b0, DONE}, 32'd0);
    check("reset_result", RESULT, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle_cycle("post_reset");

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].busy, vecs[i].name);
      idle_cycle(vecs[i].name);
    end

    // Abort mid-calculation: reset during CALC cycle 10.
    START = 1'b1;
    FUNC3 = 3'b101;
    DATA1 = 32'd1000;
    DATA2 = 32'd3;
    repeat (11) @(posedge CLK);
    #1;
    RESET = 1'b1;
    START = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("abort_busy", {31'b0, BUSYWAIT}, 32'd0);
    check("abort_done", {31'b0, DONE}, 32'd0);
    check("abort_result", RESULT, 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    @(posedge CLK);
    #1;
    run_op(3'b101, 32'd9, 32'd3, 32'd3, NormBusy, "divu_9_3_after_abort");
    idle_cycle("divu_9_3_after_abort");

    // Back-to-back: second START is seen in IDLE right after the first DONE.
    run_op(3'b101, 32'd20, 32'd4, 32'd5, NormBusy, "b2b_first");
    run_op(3'b101, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, NormBusy, "b2b_second");
    idle_cycle("b2b_second");
    idle_cycle("b2b_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
